// File: rtl/seq_match_sched.sv
// Two-requester round-robin scheduler that serially scans the granted word for "101" (overlapping).
// Latency: gnt one cycle after the request is seen in IDLE; done W+1 cycles after gnt. No backpressure: requests are only honoured in IDLE.
module seq_match_sched #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [W-1:0]      data0,
    input  logic [W-1:0]      data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic [$clog2(W):0] match_cnt
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {S0, S1, S2} det_t;

    state_t         state_q, state_d;
    det_t           det_q, det_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [CW-1:0]  bcnt_q, bcnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_q, last_d;
    logic           gnt0_q, gnt0_d;
    logic           gnt1_q, gnt1_d;
    logic           done_q, done_d;
    logic           id_q, id_d;
    logic           pick1;
    logic           cur_bit;

    always_comb begin
        state_d = state_q;
        det_d   = det_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        id_d    = id_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done_d  = 1'b0;
        // Requester 1 wins a tie only if requester 0 had the previous grant.
        pick1   = req1 && (!req0 || !last_q);
        cur_bit = sh_q[W-1];
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt0_d  = !pick1;
                    gnt1_d  = pick1;
                    last_d  = pick1;
                    id_d    = pick1;
                    sh_d    = pick1 ? data1 : data0;
                    bcnt_d  = '0;
                    cnt_d   = '0;
                    det_d   = S0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d   = {sh_q[W-2:0], 1'b0};
                bcnt_d = bcnt_q + CW'(1);
                case (det_q)
                    S0:      det_d = cur_bit ? S1 : S0;
                    S1:      det_d = cur_bit ? S1 : S2;
                    S2:      det_d = cur_bit ? S1 : S0;
                    default: det_d = S0;
                endcase
                if (det_q == S2 && cur_bit) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (bcnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            det_q   <= S0;
            sh_q    <= '0;
            bcnt_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            id_q    <= id_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done_q  <= done_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign done_id   = id_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_match_sched.sv
// Directed self-checking bench for seq_match_sched with W=8.
module tb_seq_match_sched;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         req0, req1;
    logic [W-1:0] data0, data1;
    logic         gnt0, gnt1, busy, done, done_id;
    logic [$clog2(W):0] match_cnt;

    int n_cmp = 0;
    int n_err = 0;

    seq_match_sched #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .busy(busy), .done(done), .done_id(done_id),
        .match_cnt(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request, scrambles data after the granting edge, and returns
    // the cycle offset of done relative to the gnt cycle (-1 on timeout).
    task automatic run_job(input logic r0, input logic r1,
                           input logic [W-1:0] d0, input logic [W-1:0] d1,
                           output logic g0, output logic g1, output int lat);
        @(negedge clk);
        req0 = r0; req1 = r1; data0 = d0; data1 = d1;
        @(posedge clk); #1;
        g0 = gnt0; g1 = gnt1;
        req0 = 1'b0; req1 = 1'b0;
        data0 = W'($urandom); data1 = W'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({gnt0, gnt1, busy, done, done_id} !== 5'b0) begin
            n_err++; $display("FAIL reset_outs: got %b want 00000", {gnt0, gnt1, busy, done, done_id});
        end
        n_cmp++;
        if (match_cnt !== '0) begin
            n_err++; $display("FAIL reset_cnt: got %0d want 0", match_cnt);
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_basic();
        logic g0, g1; int lat;
        run_job(1'b1, 1'b0, 8'b10101010, 8'h00, g0, g1, lat);
        n_cmp++;
        if ({g0, g1} !== 2'b10) begin n_err++; $display("FAIL basic_gnt: got %b want 10", {g0, g1}); end
        n_cmp++;
        if (lat !== W + 1) begin n_err++; $display("FAIL basic_lat: got %0d want %0d", lat, W + 1); end
        n_cmp++;
        if (done_id !== 1'b0) begin n_err++; $display("FAIL basic_id: got %b want 0", done_id); end
        n_cmp++;
        if (match_cnt !== 4'd3) begin n_err++; $display("FAIL basic_cnt: got %0d want 3", match_cnt); end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %b want 0", done); end
        n_cmp++;
        if (match_cnt !== 4'd3 || done_id !== 1'b0) begin
            n_err++; $display("FAIL hold: got cnt=%0d id=%b want cnt=3 id=0", match_cnt, done_id);
        end
    endtask

    task automatic test_req1();
        logic g0, g1; int lat;
        run_job(1'b0, 1'b1, 8'h00, 8'b10110101, g0, g1, lat);
        n_cmp++;
        if ({g0, g1} !== 2'b01) begin n_err++; $display("FAIL r1a_gnt: got %b want 01", {g0, g1}); end
        n_cmp++;
        if (lat !== W + 1 || done_id !== 1'b1 || match_cnt !== 4'd3) begin
            n_err++; $display("FAIL r1a_res: got lat=%0d id=%b cnt=%0d want lat=9 id=1 cnt=3", lat, done_id, match_cnt);
        end
        run_job(1'b0, 1'b1, 8'h00, 8'b01001010, g0, g1, lat);
        n_cmp++;
        if (lat !== W + 1 || done_id !== 1'b1 || match_cnt !== 4'd1) begin
            n_err++; $display("FAIL r1b_res: got lat=%0d id=%b cnt=%0d want lat=9 id=1 cnt=1", lat, done_id, match_cnt);
        end
    endtask

    task automatic test_edges();
        logic g0, g1; int lat;
        run_job(1'b1, 1'b0, 8'hFF, 8'h00, g0, g1, lat);
        n_cmp++;
        if (lat !== W + 1 || match_cnt !== 4'd0 || done_id !== 1'b0) begin
            n_err++; $display("FAIL ones: got lat=%0d cnt=%0d id=%b want lat=9 cnt=0 id=0", lat, match_cnt, done_id);
        end
        run_job(1'b1, 1'b0, 8'h00, 8'h00, g0, g1, lat);
        n_cmp++;
        if (lat !== W + 1 || match_cnt !== 4'd0) begin
            n_err++; $display("FAIL zeros: got lat=%0d cnt=%0d want lat=9 cnt=0", lat, match_cnt);
        end
    endtask

    task automatic test_round_robin();
        int gc[4];
        logic gw[4];
        int ng = 0;
        int both = 0;
        @(negedge clk);
        reset = 1'b0; req0 = 1; req1 = 1; data0 = 8'b10101010; data1 = 8'b10110101;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 80 && ng < 4; c++) begin
            @(posedge clk); #1;
            if (gnt0 && gnt1) both++;
            if (gnt0 || gnt1) begin
                gc[ng] = c; gw[ng] = gnt1; ng++;
            end
        end
        req0 = 0; req1 = 0;
        n_cmp++;
        if (ng !== 4) begin n_err++; $display("FAIL rr_count: got %0d grants want 4", ng); end
        n_cmp++;
        if (both !== 0) begin n_err++; $display("FAIL rr_both: got %0d overlaps want 0", both); end
        if (ng == 4) begin
            n_cmp++;
            if (gc[0] !== 1) begin n_err++; $display("FAIL rr_first: got cycle %0d want 1", gc[0]); end
            n_cmp++;
            if ({gw[0], gw[1], gw[2], gw[3]} !== 4'b0101) begin
                n_err++; $display("FAIL rr_order: got %b want 0101", {gw[0], gw[1], gw[2], gw[3]});
            end
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (gc[i] - gc[i-1] !== W + 2) begin
                    n_err++; $display("FAIL rr_space%0d: got %0d want %0d", i, gc[i] - gc[i-1], W + 2);
                end
            end
        end
        repeat (W + 4) @(posedge clk);
    endtask

    task automatic test_mid_reset();
        int spur = 0;
        int lat = -1;
        @(negedge clk);
        req1 = 1; data1 = 8'b10101010;
        @(posedge clk); #1;
        req1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({gnt0, gnt1, busy, done, done_id} !== 5'b0 || match_cnt !== '0) begin
            n_err++; $display("FAIL mid_reset: got flags=%b cnt=%0d want 00000 cnt=0",
                              {gnt0, gnt1, busy, done, done_id}, match_cnt);
        end
        req0 = 1; data0 = 8'b10110101;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || busy) spur++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (gnt0 !== 1'b1 || spur !== 0) begin
            n_err++; $display("FAIL post_reset_gnt: got gnt0=%b spurious=%0d want gnt0=1 spurious=0", gnt0, spur);
        end
        req0 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        n_cmp++;
        if (lat !== W + 1 || match_cnt !== 4'd3 || done_id !== 1'b0) begin
            n_err++; $display("FAIL post_reset_job: got lat=%0d cnt=%0d id=%b want lat=9 cnt=3 id=0", lat, match_cnt, done_id);
        end
    endtask

    task automatic test_capture();
        int lat = -1;
        int g1c = -1;
        int bad = 0;
        @(negedge clk);
        req0 = 1; data0 = 8'b10101010;
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        data0 = 8'h00; req1 = 1; data1 = 8'b01001010;
        for (int k = 1; k <= 40 && g1c < 0; k++) begin
            @(posedge clk); #1;
            if (done && lat < 0) begin
                lat = k;
                n_cmp++;
                if (match_cnt !== 4'd3) begin
                    n_err++; $display("FAIL capture_cnt: got %0d want 3", match_cnt);
                end
            end
            if (gnt1) begin
                g1c = k;
                req1 = 0;
                data1 = 8'h00;
            end else if (gnt0) begin
                bad++;
            end
        end
        n_cmp++;
        if (lat !== W + 1 || g1c !== W + 2 || bad !== 0) begin
            n_err++; $display("FAIL capture_order: got done@%0d gnt1@%0d stray=%0d want done@9 gnt1@10 stray=0", lat, g1c, bad);
        end
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        n_cmp++;
        if (lat !== W + 1 || match_cnt !== 4'd1 || done_id !== 1'b1) begin
            n_err++; $display("FAIL capture_req1: got lat=%0d cnt=%0d id=%b want lat=9 cnt=1 id=1", lat, match_cnt, done_id);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req1();
        test_edges();
        test_round_robin();
        test_mid_reset();
        test_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
